interweave_engine: RTL and testbench

Sequential, multi-layer successor to the combinational single-layer interweave stage. The block accepts one X_SIZE-bit activation vector and applies up to NUM_LAYERS interweave layers in place on an internal state register, one layer per accepted weight beat. Layer t uses stride 3^t. The result is returned on a valid/ready output port. It sits between the activation buffer and the weight streamer in the ternary-stride inference datapath.

---
 rtl/interweave_engine.sv | 117 +++++++++++
 tb/tb_interweave_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interweave_engine.sv
// Multi-layer interweave engine: one activation vector is folded in place through up to
// NUM_LAYERS weighted-majority layers (stride 3^t), one layer per accepted weight beat.

module weighted_majority (
    input  logic [2:0] x3,
    input  logic [2:0] w,
    output logic       y
);
    logic [2:0] v;
    assign v = x3 ^ w;
    assign y = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
endmodule

module interweave_engine #(
    parameter  int X_SIZE     = 729,
    parameter  int NUM_LAYERS = 6,
    localparam int LW         = $clog2(NUM_LAYERS + 1)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [X_SIZE-1:0]   x_in,
    input  logic [LW-1:0]       layers_in,
    input  logic                x_valid_in,
    output logic                x_ready_out,
    input  logic [3*X_SIZE-1:0] w_in,
    input  logic                w_valid_in,
    output logic                w_ready_out,
    output logic [X_SIZE-1:0]   y_out,
    output logic                y_valid_out,
    input  logic                y_ready_in,
    output logic [LW-1:0]       layer_out
);
    localparam int MSEL = 2 ** LW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [X_SIZE-1:0] st, st_nxt, layer_nxt;
    logic [LW-1:0]     cnt, cnt_nxt, n, n_nxt;
    logic              live;

    function automatic int stride_of(input int t);
        int s;
        s = 1 % X_SIZE;
        for (int k = 0; k < t; k++) s = (s * 3) % X_SIZE;
        return s;
    endfunction

    // Mux taps past NUM_LAYERS use stride 0 so the counter can index the full 2^LW range.
    for (genvar i = 0; i < X_SIZE; i++) begin : g_cell
        logic [MSEL-1:0] lft, rgt;
        for (genvar t = 0; t < MSEL; t++) begin : g_tap
            localparam int S = (t < NUM_LAYERS) ? stride_of(t) : 0;
            assign lft[t] = st[(i + X_SIZE - S) % X_SIZE];
            assign rgt[t] = st[(i + S) % X_SIZE];
        end
        weighted_majority u_wm (
            .x3 ({lft[cnt], rgt[cnt], st[i]}),
            .w  (w_in[3*i +: 3]),
            .y  (layer_nxt[i])
        );
    end

    // live keeps x_ready low until the first edge after reset is released.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            st    <= '0;
            cnt   <= '0;
            n     <= '0;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            st    <= st_nxt;
            cnt   <= cnt_nxt;
            n     <= n_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        st_nxt      = st;
        cnt_nxt     = cnt;
        n_nxt       = n;
        x_ready_out = 1'b0;
        w_ready_out = 1'b0;
        y_valid_out = 1'b0;
        case (state)
            IDLE: begin
                x_ready_out = live;
                if (live && x_valid_in) begin
                    st_nxt    = x_in;
                    cnt_nxt   = '0;
                    n_nxt     = (layers_in > LW'(NUM_LAYERS)) ? LW'(NUM_LAYERS) : layers_in;
                    state_nxt = (layers_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                w_ready_out = 1'b1;
                if (w_valid_in) begin
                    st_nxt  = layer_nxt;
                    cnt_nxt = cnt + LW'(1);
                    if (cnt == n - LW'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                y_valid_out = 1'b1;
                if (y_ready_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign y_out     = st;
    assign layer_out = cnt;
endmodule

// File: tb/tb_interweave_engine.sv
// Scoreboard bench for interweave_engine at X_SIZE=9, NUM_LAYERS=4.
module tb_interweave_engine;
    localparam int X  = 9;
    localparam int NL = 4;
    localparam int LW = $clog2(NL + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [X-1:0]  x_in = '0;
    logic [LW-1:0] layers_in = '0;
    logic          x_valid_in = 1'b0;
    logic          x_ready_out;
    logic [3*X-1:0] w_in = '0;
    logic          w_valid_in = 1'b0;
    logic          w_ready_out;
    logic [X-1:0]  y_out;
    logic          y_valid_out;
    logic          y_ready_in = 1'b1;
    logic [LW-1:0] layer_out;

    interweave_engine #(.X_SIZE(X), .NUM_LAYERS(NL)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .x_in        (x_in),
        .layers_in   (layers_in),
        .x_valid_in  (x_valid_in),
        .x_ready_out (x_ready_out),
        .w_in        (w_in),
        .w_valid_in  (w_valid_in),
        .w_ready_out (w_ready_out),
        .y_out       (y_out),
        .y_valid_out (y_valid_out),
        .y_ready_in  (y_ready_in),
        .layer_out   (layer_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int             n_cmp = 0;
    int             n_bad = 0;
    bit             tmo = 1'b0;
    logic [X-1:0]   exp_q[$];
    logic [3*X-1:0] wbuf[0:NL-1];
    logic [LW-1:0]  lo_trace[0:NL];
    logic [LW-1:0]  lo_stall0, lo_stall1;

    function automatic logic [X-1:0] ref_layer(input logic [X-1:0] s, input logic [3*X-1:0] w, input int t);
        int sd, ones;
        logic [X-1:0] r;
        sd = 1;
        for (int k = 0; k < t; k++) sd = (sd * 3) % X;
        for (int i = 0; i < X; i++) begin
            ones = int'(s[i] ^ w[3*i]) + int'(s[(i + sd) % X] ^ w[3*i+1])
                 + int'(s[(i + X - sd) % X] ^ w[3*i+2]);
            r[i] = (ones >= 2);
        end
        return r;
    endfunction

    function automatic logic [X-1:0] ref_vec(input logic [X-1:0] x, input int nl);
        logic [X-1:0] s;
        s = x;
        for (int t = 0; t < nl; t++) s = ref_layer(s, wbuf[t], t);
        return s;
    endfunction

    // Sends one vector and streams its weights; returns y and x-to-y_valid latency in cycles.
    task automatic drive_vector(input logic [X-1:0] x, input int lay, input int stall_at, input int stall,
                                output logic [X-1:0] y, output int lat);
        int nb, k, t0;
        nb = (lay > NL) ? NL : lay;
        @(negedge clk);
        x_in = x; layers_in = LW'(lay); x_valid_in = 1'b1;
        k = 0;
        while (!x_ready_out && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) tmo = 1'b1;
        t0 = cyc;
        @(posedge clk);
        @(negedge clk);
        x_valid_in = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (b == stall_at) begin
                lo_stall0 = layer_out;
                repeat (stall) @(negedge clk);
                lo_stall1 = layer_out;
            end
            lo_trace[b] = layer_out;
            w_in = wbuf[b]; w_valid_in = 1'b1;
            k = 0;
            while (!w_ready_out && k < 50) begin @(negedge clk); k++; end
            if (k >= 50) tmo = 1'b1;
            @(negedge clk);
            w_valid_in = 1'b0;
        end
        k = 0;
        while (!y_valid_out && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) tmo = 1'b1;
        lo_trace[nb] = layer_out;
        y = y_out;
        lat = cyc - t0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; x_valid_in = 1'b1; w_valid_in = 1'b1; w_in = '1;
        repeat (3) @(negedge clk);
        n_cmp++; if (x_ready_out !== 1'b0) begin n_bad++; $display("FAIL reset_x_ready got %b want 0", x_ready_out); end
        n_cmp++; if (w_ready_out !== 1'b0) begin n_bad++; $display("FAIL reset_w_ready got %b want 0", w_ready_out); end
        n_cmp++; if (y_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_y_valid got %b want 0", y_valid_out); end
        n_cmp++; if (y_out !== '0) begin n_bad++; $display("FAIL reset_y_out got %h want 0", y_out); end
        n_cmp++; if (layer_out !== '0) begin n_bad++; $display("FAIL reset_layer got %0d want 0", layer_out); end
        rst_n = 1'b1; x_valid_in = 1'b0; w_valid_in = 1'b0;
        @(negedge clk);
        n_cmp++; if (x_ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_release_x_ready got %b want 1", x_ready_out); end
    endtask

    task automatic test_wrap();
        logic [X-1:0] y, e;
        int lat;
        wbuf[0] = '0;
        exp_q.push_back(9'h101);
        drive_vector(9'h101, 1, -1, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_bad++; $display("FAIL wrap_y got %h want %h", y, e); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wrap_latency got %0d want 2", lat); end
    endtask

    task automatic test_inversion();
        logic [X-1:0] y, e;
        int lat;
        wbuf[0] = '1;
        exp_q.push_back(9'h1F8);
        drive_vector(9'h007, 1, -1, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_bad++; $display("FAIL invert_ones got %h want %h", y, e); end
        wbuf[0] = '0;
        exp_q.push_back(9'h007);
        drive_vector(9'h007, 1, -1, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_bad++; $display("FAIL invert_zeros got %h want %h", y, e); end
    endtask

    task automatic test_stride_select();
        logic [X-1:0] y, e;
        int lat;
        wbuf[0] = '0; wbuf[1] = '0;
        exp_q.push_back(9'h000);
        drive_vector(9'h049, 2, -1, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_bad++; $display("FAIL stride_y got %h want %h", y, e); end
        for (int b = 0; b <= 2; b++) begin
            n_cmp++;
            if (lo_trace[b] !== LW'(b)) begin n_bad++; $display("FAIL stride_layer_out[%0d] got %0d want %0d", b, lo_trace[b], b); end
        end
    endtask

    task automatic test_zero_backpressure();
        logic [X-1:0] y, e;
        int lat;
        w_in = '1; w_valid_in = 1'b1;
        @(negedge clk);
        n_cmp++; if (w_ready_out !== 1'b0) begin n_bad++; $display("FAIL idle_w_ready got %b want 0", w_ready_out); end
        y_ready_in = 1'b0;
        exp_q.push_back(9'h0AB);
        drive_vector(9'h0AB, 0, -1, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_bad++; $display("FAIL zero_layers_y got %h want %h", y, e); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL zero_layers_latency got %0d want 1", lat); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (y_out !== e) begin n_bad++; $display("FAIL bp_y_hold c%0d got %h want %h", c, y_out, e); end
            n_cmp++; if (y_valid_out !== 1'b1) begin n_bad++; $display("FAIL bp_y_valid c%0d got %b want 1", c, y_valid_out); end
            n_cmp++; if (x_ready_out !== 1'b0 || w_ready_out !== 1'b0) begin
                n_bad++; $display("FAIL bp_ready c%0d got x=%b w=%b want 0/0", c, x_ready_out, w_ready_out);
            end
        end
        y_ready_in = 1'b1; w_valid_in = 1'b0;
        @(negedge clk);
        n_cmp++; if (x_ready_out !== 1'b1 || y_valid_out !== 1'b0) begin
            n_bad++; $display("FAIL bp_release got x_ready=%b y_valid=%b want 1/0", x_ready_out, y_valid_out);
        end
    endtask

    task automatic test_weight_stall();
        logic [X-1:0] y1, y2, e;
        int lat1, lat2;
        wbuf[0] = 27'h5A3C1E7; wbuf[1] = 27'h12F0D4B;
        exp_q.push_back(ref_vec(9'h15A, 2));
        drive_vector(9'h15A, 2, -1, 0, y1, lat1);
        e = exp_q.pop_front();
        n_cmp++; if (y1 !== e) begin n_bad++; $display("FAIL nostall_y got %h want %h", y1, e); end
        n_cmp++; if (lat1 !== 3) begin n_bad++; $display("FAIL nostall_latency got %0d want 3", lat1); end
        exp_q.push_back(ref_vec(9'h15A, 2));
        drive_vector(9'h15A, 2, 1, 3, y2, lat2);
        e = exp_q.pop_front();
        n_cmp++; if (y2 !== e) begin n_bad++; $display("FAIL stall_y got %h want %h", y2, e); end
        n_cmp++; if (lat2 !== 6) begin n_bad++; $display("FAIL stall_latency got %0d want 6", lat2); end
        n_cmp++; if (lo_stall0 !== LW'(1) || lo_stall1 !== LW'(1)) begin
            n_bad++; $display("FAIL stall_layer_hold got %0d->%0d want 1->1", lo_stall0, lo_stall1);
        end
    endtask

    task automatic test_clamp();
        logic [X-1:0] y, e;
        int lat;
        for (int b = 0; b < NL; b++) wbuf[b] = 27'($urandom);
        exp_q.push_back(ref_vec(9'h0C3, NL));
        drive_vector(9'h0C3, 7, -1, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_bad++; $display("FAIL clamp_y got %h want %h", y, e); end
        n_cmp++; if (lat !== NL + 1) begin n_bad++; $display("FAIL clamp_latency got %0d want %0d", lat, NL + 1); end
        n_cmp++; if (lo_trace[NL] !== LW'(NL)) begin n_bad++; $display("FAIL clamp_layer_out got %0d want %0d", lo_trace[NL], NL); end
    endtask

    task automatic test_back_to_back();
        logic [X-1:0] x, y, e;
        int lay, lat;
        for (int v = 0; v < 8; v++) begin
            x = X'($urandom);
            lay = (v < 5) ? v : int'($urandom_range(0, NL));
            for (int b = 0; b < NL; b++) wbuf[b] = 27'($urandom);
            exp_q.push_back(ref_vec(x, lay));
            drive_vector(x, lay, -1, 0, y, lat);
            e = exp_q.pop_front();
            n_cmp++; if (y !== e) begin n_bad++; $display("FAIL b2b_y v%0d L%0d got %h want %h", v, lay, y, e); end
            n_cmp++; if (lat !== lay + 1) begin n_bad++; $display("FAIL b2b_latency v%0d got %0d want %0d", v, lat, lay + 1); end
        end
    endtask

    task automatic test_reset_midop();
        logic [X-1:0] y, e;
        int lat, k;
        for (int b = 0; b < NL; b++) wbuf[b] = 27'($urandom);
        @(negedge clk);
        x_in = 9'h1E5; layers_in = LW'(3); x_valid_in = 1'b1;
        k = 0;
        while (!x_ready_out && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) tmo = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_valid_in = 1'b0; w_in = wbuf[0]; w_valid_in = 1'b1;
        @(negedge clk);
        w_in = wbuf[1]; rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (x_ready_out !== 1'b0 || w_ready_out !== 1'b0 || y_valid_out !== 1'b0) begin
            n_bad++; $display("FAIL midreset_ctl got x=%b w=%b yv=%b want 0/0/0", x_ready_out, w_ready_out, y_valid_out);
        end
        n_cmp++; if (y_out !== '0) begin n_bad++; $display("FAIL midreset_y got %h want 0", y_out); end
        n_cmp++; if (layer_out !== '0) begin n_bad++; $display("FAIL midreset_layer got %0d want 0", layer_out); end
        rst_n = 1'b1; w_valid_in = 1'b0;
        #1;
        n_cmp++; if (x_ready_out !== 1'b0) begin n_bad++; $display("FAIL midreset_early_ready got %b want 0", x_ready_out); end
        @(negedge clk);
        n_cmp++; if (x_ready_out !== 1'b1) begin n_bad++; $display("FAIL midreset_release got %b want 1", x_ready_out); end
        exp_q.push_back(ref_vec(9'h0F0, 3));
        drive_vector(9'h0F0, 3, -1, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_bad++; $display("FAIL midreset_fresh_y got %h want %h", y, e); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL midreset_fresh_latency got %0d want 4", lat); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_inversion();
        test_stride_select();
        test_zero_backpressure();
        test_weight_stall();
        test_clamp();
        test_back_to_back();
        test_reset_midop();
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL handshake_timeout got 1 want 0"); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
